axi_demux_1xn_reg: RTL and testbench
====================================

# axi_demux_1xn_reg

Registered, parametrised 1-to-N demultiplexer for one AXI channel (AW/W/AR payload stream) in the interconnect datapath. Routes each accepted beat to exactly one of NUM_OUT downstream ports using a valid/ready handshake. Provides a two-entry skid buffer for full throughput, burst locking on LAST, and decode-error absorption for out-of-range selects. Non-selected output lanes are driven to zero.

## Interface
- WIDTH, default 32: payload bits per beat.
- NUM_OUT, default 4: number of output ports, 2..16.
- SEL_W, default $clog2(NUM_OUT): select width. Derived; never overridden.
- ACLK  in  1: clock, rising edge.
- ARESETN  in  1: reset, asynchronous, active-low.
- s_valid  in  1: input beat valid.
- s_ready  out  1: input beat accepted when s_valid && s_ready.
- s_data  in  WIDTH: input payload.
- s_sel  in  SEL_W: destination index. Sampled only on the first beat of a burst.
- s_last  in  1: final beat of burst.
- m_valid  out  NUM_OUT: per-port valid, one-hot or zero.
- m_ready  in  NUM_OUT: per-port ready.
- m_data  out  NUM_OUT*WIDTH: flattened. Lane k = bits [k*WIDTH +: WIDTH]. Lanes not currently valid are 0.
- m_last  out  NUM_OUT: per-port last. 0 on lanes not valid.
- dec_err  out  1: one-cycle pulse per dropped beat.
- err_count  out  8: dropped-beat count, saturating at 255.

## Operation
- Storage is one output register plus one skid register. Each holds {valid, port, data, last}.
- s_ready = !skid_valid. It is forced to 0 while ARESETN is low.
- Accept, output register empty or draining this cycle: beat goes to the output register.
- Accept, output register held (m_ready[port]=0): beat goes to the skid register.
- When the output register drains and skid is full, skid moves to the output register and skid clears.
- Beats leave strictly in acceptance order. A stalled port blocks all ports (head-of-line).
- Burst lock, states IDLE and LOCKED:
  - IDLE: accepted beat uses s_sel. If s_last=0, latch the port and enter LOCKED.
  - LOCKED: every accepted beat uses the latched port; s_sel is ignored. An accepted beat with s_last=1 returns to IDLE.
  - A single-beat burst (s_last=1 in IDLE) never enters LOCKED.
- Decode error: effective port >= NUM_OUT (possible only when NUM_OUT is not a power of two).
  - The beat is accepted and not stored; no m_valid is raised.
  - dec_err pulses the following cycle and err_count increments.
  - Burst lock applies to the error port as well, so the remaining beats of that burst are also dropped, each one counted.
- Output: m_valid[k] = out_valid && out_port==k. m_data lane k = out_data when m_valid[k], else 0. m_last follows the same rule.

## Timing
- Reset (async assert, sync release) values: m_valid=0, m_data=0, m_last=0, dec_err=0, err_count=0, s_ready=0, FSM=IDLE, both buffers empty.
- First cycle after release: s_ready=1.
- Latency: a beat accepted at edge n is visible on m_* after edge n. This is one cycle of latency, with no combinational path from s_* to m_*.
- Throughput: one beat per cycle while the destination keeps m_ready high.
- Ready path: s_ready is a register output, with no combinational path from m_ready to s_ready.
- Full condition: both entries occupied, so s_ready=0. s_ready rises on the edge after the output register drains.
- Simultaneous accept and drain while skid is empty: the new beat replaces the output register in the same edge.
- ARESETN asserted mid-burst: buffers are flushed, FSM goes to IDLE, err_count clears, and in-flight beats are lost.
- m_valid/m_data for a port stay stable while m_ready[port]=0 (AXI rule).

## Test plan
- Reset then routing, NUM_OUT=4, WIDTH=32: send s_sel=0..3 with data 0x11111111..0x44444444, s_last=1, all m_ready=1 -> each data appears on lane k one cycle later with m_valid one-hot; all other lanes 0; 4 beats in 4 cycles.
- Burst lock: s_sel=2, 4 beats 0xA0..0xA3, s_sel changed to 1 from beat 2 onward, last on beat 4 -> all 4 beats on port 2; next burst with s_sel=1 goes to port 1.
- Backpressure: m_ready[1]=0 for 5 cycles during a stream to port 1 -> s_ready falls after 2 beats are held; output data stays stable; no beat lost or duplicated; order preserved after release.
- Decode error, NUM_OUT=3: s_sel=3, 3-beat burst -> no m_valid; dec_err pulses 3 times; err_count=3. Then drive 260 error beats -> err_count saturates at 255.
- Reset mid-burst: assert ARESETN low during beat 2 of a port-0 burst -> all outputs are 0 immediately; after release, s_sel=3 routes to port 3 (FSM back in IDLE).
- Head-of-line: port 0 stalled while a beat for port 1 is queued behind it -> port 1 m_valid stays 0 until port 0 drains.

Source files
------------

// File: rtl/axi_demux_1xn_reg.sv
// Registered 1-to-N demultiplexer for one AXI payload channel.
// Two-entry skid buffer, burst lock on LAST, decode-error absorption.
module axi_demux_1xn_reg #(
  parameter int WIDTH   = 32,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  input  logic [SEL_W-1:0]         s_sel,
  input  logic                     s_last,
  output logic [NUM_OUT-1:0]       m_valid,
  input  logic [NUM_OUT-1:0]       m_ready,
  output logic [NUM_OUT*WIDTH-1:0] m_data,
  output logic [NUM_OUT-1:0]       m_last,
  output logic                     dec_err,
  output logic [7:0]               err_count
);

  localparam logic [SEL_W:0] NUM_OUT_V = (SEL_W+1)'(NUM_OUT);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] port;
    logic [WIDTH-1:0] data;
    logic             last;
  } ent_t;

  state_t           state;
  state_t           state_n;
  logic [SEL_W-1:0] lock_port;
  logic [SEL_W-1:0] eff_port;
  logic             bad_port;
  logic             acc;
  logic             store;
  logic             drain;
  logic             out_free;
  logic             rdy_q;
  ent_t             out_q;
  ent_t             skid_q;
  ent_t             out_n;
  ent_t             skid_n;
  ent_t             in_ent;

  assign s_ready  = rdy_q;
  assign acc      = s_valid && rdy_q;
  assign bad_port = {1'b0, eff_port} >= NUM_OUT_V;
  assign store    = acc && !bad_port;
  assign drain    = |(m_valid & m_ready);
  assign out_free = !out_q.valid || drain;

  assign in_ent.valid = 1'b1;
  assign in_ent.port  = eff_port;
  assign in_ent.data  = s_data;
  assign in_ent.last  = s_last;

  // Burst-lock state and latched destination
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      lock_port <= '0;
    end else begin
      state <= state_n;
      if (acc && state == IDLE && !s_last)
        lock_port <= s_sel;
    end
  end

  // Lock on a non-final beat, release on the final one
  always_comb begin
    state_n = state;
    if (acc) begin
      unique case (state)
        IDLE:    if (!s_last) state_n = LOCKED;
        LOCKED:  if (s_last)  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Destination for the current beat: s_sel only at burst start
  always_comb begin
    eff_port = s_sel;
    if (state == LOCKED)
      eff_port = lock_port;
  end

  // Buffer steering: skid feeds the output register first
  always_comb begin
    out_n  = out_q;
    skid_n = skid_q;
    if (out_free) begin
      if (skid_q.valid) begin
        out_n  = skid_q;
        skid_n = '0;
        if (store)
          skid_n = in_ent;
      end else if (store) begin
        out_n = in_ent;
      end else begin
        out_n.valid = 1'b0;
      end
    end else if (store) begin
      skid_n = in_ent;
    end
  end

  // Storage and registered ready
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_q  <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      out_q  <= out_n;
      skid_q <= skid_n;
      rdy_q  <= !skid_n.valid;
    end
  end

  // Dropped-beat pulse and saturating count
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dec_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      dec_err <= acc && bad_port;
      if (acc && bad_port && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Fan the output register onto its lane; idle lanes read zero
  always_comb begin
    m_valid = '0;
    m_data  = '0;
    m_last  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (out_q.valid && out_q.port == SEL_W'(k)) begin
        m_valid[k]                = 1'b1;
        m_data[k*WIDTH +: WIDTH]  = out_q.data;
        m_last[k]                 = out_q.last;
      end
    end
  end

endmodule

// File: tb/tb_axi_demux_1xn_reg.sv
// Bench for axi_demux_1xn_reg: NUM_OUT=4 and NUM_OUT=3 instances.
// Scoreboard per instance plus directed checks.
module tb_axi_demux_1xn_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int de_cnt = 0;

  logic         a_sv, a_sr, a_sl, a_de;
  logic [31:0]  a_sd;
  logic [1:0]   a_sel;
  logic [3:0]   a_mv, a_mr, a_ml;
  logic [127:0] a_md;
  logic [7:0]   a_ec;

  logic         b_sv, b_sr, b_sl, b_de;
  logic [31:0]  b_sd;
  logic [1:0]   b_sel;
  logic [2:0]   b_mv, b_mr, b_ml;
  logic [95:0]  b_md;
  logic [7:0]   b_ec;

  axi_demux_1xn_reg #(.WIDTH(32), .NUM_OUT(4)) dut_a (
    .ACLK(clk), .ARESETN(rst_n),
    .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
    .s_sel(a_sel), .s_last(a_sl),
    .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
    .m_last(a_ml), .dec_err(a_de), .err_count(a_ec)
  );

  axi_demux_1xn_reg #(.WIDTH(32), .NUM_OUT(3)) dut_b (
    .ACLK(clk), .ARESETN(rst_n),
    .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
    .s_sel(b_sel), .s_last(b_sl),
    .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
    .m_last(b_ml), .dec_err(b_de), .err_count(b_ec)
  );

  typedef logic [36:0] exp_t;

  exp_t         exp_q[2][$];
  bit           locked[2];
  logic [3:0]   lport[2];
  bit           pend[2];
  int           ecm[2];
  bit           hold[2];
  logic [3:0]   pmv[2];
  logic [3:0]   pml[2];
  logic [127:0] pmd[2];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mon(input int id, input int nout,
                     input logic sv, input logic sr,
                     input logic [31:0] sd, input logic [1:0] ssel,
                     input logic sl, input logic [3:0] mv,
                     input logic [3:0] mr, input logic [127:0] md,
                     input logic [3:0] ml, input logic de,
                     input logic [7:0] ec);
    exp_t e;
    logic [3:0] p;
    if (!rst_n) begin
      chk("rst_mv", 128'(mv), 0);
      chk("rst_md", md, 0);
      chk("rst_rdy", 128'(sr), 0);
      chk("rst_ec", 128'(ec), 0);
      chk("rst_de", 128'(de), 0);
      exp_q[id].delete();
      locked[id] = 0;
      pend[id] = 0;
      ecm[id] = 0;
      hold[id] = 0;
      return;
    end
    chk("onehot", 128'($countones(mv) <= 1), 1);
    for (int k = 0; k < nout; k++) begin
      if (!mv[k]) begin
        chk("zero_lane", 128'(md[k*32 +: 32]), 0);
        chk("zero_last", 128'(ml[k]), 0);
      end
    end
    if (hold[id]) begin
      chk("stable_v", 128'(mv), 128'(pmv[id]));
      chk("stable_d", md, pmd[id]);
      chk("stable_l", 128'(ml), 128'(pml[id]));
    end
    hold[id] = |(mv & ~mr);
    pmv[id] = mv;
    pmd[id] = md;
    pml[id] = ml;
    for (int k = 0; k < nout; k++) begin
      if (mv[k] && mr[k]) begin
        if (exp_q[id].size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          e = exp_q[id].pop_front();
          chk("sb_beat", 128'({4'(k), ml[k], md[k*32 +: 32]}), 128'(e));
        end
      end
    end
    chk("dec_err", 128'(de), 128'(pend[id]));
    chk("err_cnt", 128'(ec), 128'(ecm[id]));
    pend[id] = 0;
    if (sv && sr) begin
      p = locked[id] ? lport[id] : {2'b00, ssel};
      if (int'(p) >= nout) begin
        pend[id] = 1;
        if (ecm[id] < 255) ecm[id]++;
      end else begin
        exp_q[id].push_back({p, sl, sd});
      end
      if (!locked[id] && !sl) begin
        locked[id] = 1;
        lport[id] = {2'b00, ssel};
      end else if (locked[id] && sl) begin
        locked[id] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, a_sv, a_sr, a_sd, a_sel, a_sl, a_mv, a_mr, a_md,
        a_ml, a_de, a_ec);
    mon(1, 3, b_sv, b_sr, b_sd, b_sel, b_sl, {1'b0, b_mv},
        {1'b0, b_mr}, {32'h0, b_md}, {1'b0, b_ml}, b_de, b_ec);
    if (b_de) de_cnt++;
  end

  task automatic beat(input int id, input logic [1:0] sel,
                      input logic [31:0] d, input logic l,
                      output int n);
    bit acc;
    n = 0;
    if (id == 0) begin
      a_sv = 1'b1; a_sel = sel; a_sd = d; a_sl = l;
    end else begin
      b_sv = 1'b1; b_sel = sel; b_sd = d; b_sl = l;
    end
    do begin
      @(negedge clk);
      acc = (id == 0) ? a_sr : b_sr;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("beat_timeout", 0, 1);
  endtask

  task automatic idle();
    a_sv = 1'b0;
    b_sv = 1'b0;
  endtask

  task automatic wait_empty(input int id);
    int n = 0;
    while (exp_q[id].size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 128'(exp_q[id].size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    a_sv = 0; a_sd = 0; a_sel = 0; a_sl = 0; a_mr = 4'hF;
    b_sv = 0; b_sd = 0; b_sel = 0; b_sl = 0; b_mr = 3'h7;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_rel", 128'(a_sr), 1);

    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      beat(0, 2'(k), 32'h11111111 * (k + 1), 1'b1, n);
      cyc += n;
      chk("route_v", 128'(a_mv), 128'(4'b0001 << k));
      chk("route_d", 128'(a_md[k*32 +: 32]), 128'(32'h11111111 * (k + 1)));
    end
    chk("thru", 128'(cyc), 4);
    idle();
    wait_empty(0);

    beat(0, 2'd2, 32'hA0, 1'b0, n);
    beat(0, 2'd1, 32'hA1, 1'b0, n);
    chk("lock_v", 128'(a_mv), 128'(4'b0100));
    beat(0, 2'd1, 32'hA2, 1'b0, n);
    beat(0, 2'd1, 32'hA3, 1'b1, n);
    chk("lock_last", 128'(a_ml), 128'(4'b0100));
    beat(0, 2'd1, 32'hB1, 1'b1, n);
    chk("unlock_v", 128'(a_mv), 128'(4'b0010));
    idle();
    wait_empty(0);

    a_mr[1] = 1'b0;
    fork
      begin
        int m;
        for (int i = 0; i < 6; i++)
          beat(0, 2'd1, 32'hC0 + i, 1'b1, m);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_full", 128'(a_sr), 0);
        chk("bp_hold", 128'(a_mv), 128'(4'b0010));
        chk("bp_data", 128'(a_md[63:32]), 128'(32'hC0));
        repeat (2) @(posedge clk);
        #2 a_mr[1] = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_rise", 128'(a_sr), 1);
      end
    join
    idle();
    wait_empty(0);

    a_mr[0] = 1'b0;
    beat(0, 2'd0, 32'hD0, 1'b1, n);
    beat(0, 2'd1, 32'hD1, 1'b1, n);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("hol_p1", 128'(a_mv[1]), 0);
    end
    @(posedge clk);
    #2 a_mr[0] = 1'b1;
    wait_empty(0);

    de_cnt = 0;
    beat(1, 2'd3, 32'hF0, 1'b0, n);
    beat(1, 2'd0, 32'hF1, 1'b0, n);
    beat(1, 2'd0, 32'hF2, 1'b1, n);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("dec_cnt3", 128'(b_ec), 3);
    chk("dec_pulses", 128'(de_cnt), 3);
    chk("dec_nomv", 128'(b_mv), 0);
    beat(1, 2'd2, 32'hE2, 1'b1, n);
    chk("dec_unlock", 128'(b_mv), 128'(3'b100));
    for (int i = 0; i < 260; i++)
      beat(1, 2'd3, 32'(i), 1'b1, n);
    idle();
    @(posedge clk);
    #1;
    chk("dec_sat", 128'(b_ec), 255);
    wait_empty(1);

    beat(0, 2'd0, 32'h50, 1'b0, n);
    a_sd = 32'h51;
    a_sl = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mr_v", 128'(a_mv), 0);
    chk("mr_d", a_md, 0);
    chk("mr_l", 128'(a_ml), 0);
    chk("mr_rdy", 128'(a_sr), 0);
    chk("mr_ec", 128'(b_ec), 0);
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(0, 2'd3, 32'h60, 1'b1, n);
    chk("mr_route", 128'(a_mv), 128'(4'b1000));
    chk("mr_data", 128'(a_md[127:96]), 128'(32'h60));
    idle();
    wait_empty(0);
    wait_empty(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
